// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl bus: request ports, ALU drive/return and response handshake.
// master = sequencer side, slave = the requesters, ALU and response consumer.
interface alu_seq_ctrl_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_dat1;
    logic [31:0] req0_dat2;
    logic [4:0]  req0_instr;
    logic [31:0] req1_dat1;
    logic [31:0] req1_dat2;
    logic [4:0]  req1_instr;

    logic        alu_dat_ready;
    logic [31:0] alu_dat1;
    logic [31:0] alu_dat2;
    logic [4:0]  alu_instr;
    logic        alu_ready;
    logic [31:0] alu_out;
    logic        alu_overflow;
    logic        alu_con_met;
    logic        alu_zero;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_out;
    logic [3:0]  rsp_flags;

    modport master (
        input  req_valid, req0_dat1, req0_dat2, req0_instr,
        input  req1_dat1, req1_dat2, req1_instr,
        output req_ready,
        output alu_dat_ready, alu_dat1, alu_dat2, alu_instr,
        input  alu_ready, alu_out, alu_overflow, alu_con_met, alu_zero,
        output rsp_valid, rsp_id, rsp_out, rsp_flags,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req0_dat1, req0_dat2, req0_instr,
        output req1_dat1, req1_dat2, req1_instr,
        input  req_ready,
        input  alu_dat_ready, alu_dat1, alu_dat2, alu_instr,
        output alu_ready, alu_out, alu_overflow, alu_con_met, alu_zero,
        input  rsp_valid, rsp_id, rsp_out, rsp_flags,
        output rsp_ready
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Round-robin two-port sequencer in front of the ALU with watchdog timeout.
// Define ALU_SEQ_PERF_EN to add the perf_ops / perf_wait counters.
module alu_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 8,
    parameter int unsigned MAX_OPCODE     = 15
) (
    input  logic           soc_clk,
    input  logic           reset,
    alu_seq_ctrl_if.master bus
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [31:0]    perf_ops,
    output logic [31:0]    perf_wait
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [31:0] MAX_OP   = MAX_OPCODE;
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic        last_grant;
    logic [7:0]  tmo_cnt;
    logic [31:0] op_dat1;
    logic [31:0] op_dat2;
    logic [4:0]  op_instr;
    logic        rsp_id_q;
    logic [31:0] rsp_out_q;
    logic [3:0]  rsp_flags_q;

    logic        gnt;
    logic [1:0]  gnt_oh;
    logic        take;
    logic        bad_op;
    logic        tmo_hit;
    logic        rsp_fire;
    logic [31:0] sel_dat1;
    logic [31:0] sel_dat2;
    logic [4:0]  sel_instr;

    // Contested cycles go to the port that did not win last time.
    always_comb begin
        gnt = bus.req_valid[1];
        if (&bus.req_valid) gnt = ~last_grant;
        gnt_oh = 2'b00;
        if (state == S_IDLE && !reset && |bus.req_valid)
            gnt_oh = gnt ? 2'b10 : 2'b01;
        sel_dat1  = gnt ? bus.req1_dat1  : bus.req0_dat1;
        sel_dat2  = gnt ? bus.req1_dat2  : bus.req0_dat2;
        sel_instr = gnt ? bus.req1_instr : bus.req0_instr;
    end

    assign take     = |gnt_oh;
    assign bad_op   = {27'd0, sel_instr} > MAX_OP;
    assign tmo_hit  = tmo_cnt == TMO_LAST;
    assign rsp_fire = (state == S_RESP) && bus.rsp_ready;

    assign bus.req_ready     = gnt_oh;
    assign bus.alu_dat_ready = (state == S_WAIT) && !reset;
    assign bus.alu_dat1      = op_dat1;
    assign bus.alu_dat2      = op_dat2;
    assign bus.alu_instr     = op_instr;
    assign bus.rsp_valid     = state == S_RESP;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_out       = rsp_out_q;
    assign bus.rsp_flags     = rsp_flags_q;

    always_ff @(posedge soc_clk) begin
        if (reset) begin
            state       <= S_IDLE;
            last_grant  <= 1'b1;
            tmo_cnt     <= 8'd0;
            op_dat1     <= 32'd0;
            op_dat2     <= 32'd0;
            op_instr    <= 5'd0;
            rsp_id_q    <= 1'b0;
            rsp_out_q   <= 32'd0;
            rsp_flags_q <= 4'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (take) begin
                        last_grant <= gnt;
                        rsp_id_q   <= gnt;
                        // Illegal codes are answered without touching the ALU.
                        if (bad_op) begin
                            state       <= S_RESP;
                            rsp_out_q   <= 32'd0;
                            rsp_flags_q <= 4'b1000;
                        end else begin
                            state    <= S_WAIT;
                            op_dat1  <= sel_dat1;
                            op_dat2  <= sel_dat2;
                            op_instr <= sel_instr;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.alu_ready) begin
                        state       <= S_RESP;
                        tmo_cnt     <= 8'd0;
                        rsp_out_q   <= bus.alu_out;
                        rsp_flags_q <= {1'b0, bus.alu_overflow,
                                        bus.alu_con_met, bus.alu_zero};
                    end else if (tmo_hit) begin
                        state       <= S_RESP;
                        tmo_cnt     <= 8'd0;
                        rsp_out_q   <= 32'd0;
                        rsp_flags_q <= 4'b1000;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_PERF_EN
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            perf_ops  <= 32'd0;
            perf_wait <= 32'd0;
        end else begin
            if (rsp_fire) perf_ops <= perf_ops + 32'd1;
            if (state == S_WAIT) perf_wait <= perf_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized bench for alu_seq_ctrl against a transaction-level model.
// Includes a behavioural ALU with per-op latency chosen by the stimulus.
module tb_alu_seq_ctrl;

    localparam int TMO = 8;

    logic soc_clk = 1'b0;
    logic reset;
    always #5 soc_clk = ~soc_clk;

    alu_seq_ctrl_if bus();
`ifdef ALU_SEQ_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_wait;
`endif

    alu_seq_ctrl #(
        .TIMEOUT_CYCLES(TMO),
        .MAX_OPCODE(15)
    ) dut (
        .soc_clk(soc_clk),
        .reset(reset),
        .bus(bus)
`ifdef ALU_SEQ_PERF_EN
        ,
        .perf_ops(perf_ops),
        .perf_wait(perf_wait)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // next-cycle stimulus
    logic        nx_reset = 1'b1;
    logic [1:0]  nx_valid = 2'b00;
    logic [31:0] nx_a [2];
    logic [31:0] nx_b [2];
    logic [4:0]  nx_ins [2];
    int          nx_lat [2];
    logic        nx_rsp_ready = 1'b1;

    // model state
    bit          pend = 0;
    bit          m_last = 1;
    int          p_id, p_due, p_lat;
    bit          p_bad;
    logic [31:0] p_a, p_b, p_out;
    logic [4:0]  p_ins;
    logic [3:0]  p_flags;
    bit          was_reset = 1;
    bit          was_wait = 0;
    bit          hs_req = 0;
    bit          hs_rsp = 0;
    int          hs_gnt;
    logic [31:0] h_a, h_b;
    logic [4:0]  h_ins;
    int          h_lat;
    int unsigned exp_ops = 0;
    int unsigned exp_wait = 0;
    int          walu_cnt = 0;
    int          glog [$];
    logic [31:0] rlog [$];
    logic [3:0]  flog [$];
    int          ilog [$];

    function automatic logic [31:0] alu_fn(logic [4:0] ins,
                                           logic [31:0] a, logic [31:0] b);
        if (ins == 5'd6) return a + b;
        return (a ^ {b[15:0], b[31:16]}) + {27'd0, ins};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      tag, got, exp, cyc);
    endtask

    task automatic step();
        bit e_rv, e_dr;
        logic [1:0] e_rr;
        int g;
        logic [31:0] res;
        @(posedge soc_clk);
        cyc++;
        if (was_reset) begin
            pend = 0;
            m_last = 1;
            exp_ops = 0;
            exp_wait = 0;
        end else begin
            if (was_wait) exp_wait++;
            if (hs_rsp) begin
                pend = 0;
                exp_ops++;
            end
            if (hs_req) begin
                pend = 1;
                p_id = hs_gnt;
                m_last = hs_gnt[0];
                p_a = h_a;
                p_b = h_b;
                p_ins = h_ins;
                p_lat = h_lat;
                p_bad = h_ins > 5'd15;
                if (p_bad) begin
                    p_out = 0; p_flags = 4'b1000; p_due = cyc;
                end else if (p_lat >= TMO) begin
                    p_out = 0; p_flags = 4'b1000; p_due = cyc + TMO;
                end else begin
                    res = alu_fn(h_ins, h_a, h_b);
                    p_out = res;
                    p_flags = {1'b0, res[31], res[0], res == 32'd0};
                    p_due = cyc + 1 + p_lat;
                end
            end
        end
        #1;
        e_rv = pend && cyc >= p_due;
        e_dr = pend && !p_bad && cyc < p_due;
        chk("rsp_valid", bus.rsp_valid, e_rv);
        chk("alu_dat_ready", bus.alu_dat_ready, e_dr);
        if (was_reset) begin
            chk("rst_rsp_id", bus.rsp_id, 0);
            chk("rst_rsp_out", bus.rsp_out, 0);
            chk("rst_rsp_flags", bus.rsp_flags, 0);
            chk("rst_alu_dat1", bus.alu_dat1, 0);
            chk("rst_alu_dat2", bus.alu_dat2, 0);
            chk("rst_alu_instr", bus.alu_instr, 0);
        end
        if (e_dr) begin
            chk("alu_dat1", bus.alu_dat1, p_a);
            chk("alu_dat2", bus.alu_dat2, p_b);
            chk("alu_instr", bus.alu_instr, p_ins);
        end
        if (e_rv) begin
            chk("rsp_id", bus.rsp_id, p_id);
            chk("rsp_out", bus.rsp_out, p_out);
            chk("rsp_flags", bus.rsp_flags, p_flags);
        end
`ifdef ALU_SEQ_PERF_EN
        chk("perf_ops", perf_ops, exp_ops);
        chk("perf_wait", perf_wait, exp_wait);
`endif
        // behavioural ALU
        if (bus.alu_dat_ready) begin
            if (walu_cnt == p_lat) begin
                res = alu_fn(bus.alu_instr, bus.alu_dat1, bus.alu_dat2);
                bus.alu_ready = 1'b1;
                bus.alu_out = res;
                bus.alu_overflow = res[31];
                bus.alu_con_met = res[0];
                bus.alu_zero = res == 32'd0;
            end else begin
                bus.alu_ready = 1'b0;
                bus.alu_out = $urandom;
                {bus.alu_overflow, bus.alu_con_met, bus.alu_zero} = 3'($urandom);
            end
            walu_cnt++;
        end else begin
            bus.alu_ready = 1'b0;
            bus.alu_out = $urandom;
            {bus.alu_overflow, bus.alu_con_met, bus.alu_zero} = 3'($urandom);
            walu_cnt = 0;
        end
        reset = nx_reset;
        bus.req_valid = nx_valid;
        bus.req0_dat1 = nx_a[0];
        bus.req0_dat2 = nx_b[0];
        bus.req0_instr = nx_ins[0];
        bus.req1_dat1 = nx_a[1];
        bus.req1_dat2 = nx_b[1];
        bus.req1_instr = nx_ins[1];
        bus.rsp_ready = nx_rsp_ready;
        #1;
        e_rr = 2'b00;
        g = 0;
        if (!pend && !nx_reset && |nx_valid) begin
            g = (&nx_valid) ? int'(!m_last) : int'(nx_valid[1]);
            e_rr = (g == 1) ? 2'b10 : 2'b01;
        end
        chk("req_ready", bus.req_ready, e_rr);
        hs_req = e_rr != 2'b00;
        hs_gnt = g;
        h_a = nx_a[g];
        h_b = nx_b[g];
        h_ins = nx_ins[g];
        h_lat = nx_lat[g];
        if (hs_req) glog.push_back(bus.req_ready == 2'b10 ? 1 : 0);
        hs_rsp = e_rv && nx_rsp_ready && !nx_reset;
        if (hs_rsp) begin
            rlog.push_back(bus.rsp_out);
            flog.push_back(bus.rsp_flags);
            ilog.push_back(int'(bus.rsp_id));
        end
        was_wait = e_dr && !nx_reset;
        was_reset = nx_reset;
    endtask

    task automatic drain(int n);
        repeat (n) step();
    endtask

    task automatic issue(int port, logic [4:0] ins,
                         logic [31:0] a, logic [31:0] b, int lat);
        bit ok = 0;
        nx_valid = (port == 1) ? 2'b10 : 2'b01;
        nx_a[port] = a;
        nx_b[port] = b;
        nx_ins[port] = ins;
        nx_lat[port] = lat;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            ok = hs_req;
        end
        nx_valid = 2'b00;
        chk("accept", ok, 1);
    endtask

    initial begin
        bit ok;
        int start;
        reset = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        bus.alu_ready = 1'b0;
        bus.alu_out = 32'd0;
        {bus.alu_overflow, bus.alu_con_met, bus.alu_zero} = 3'd0;
        for (int p = 0; p < 2; p++) begin
            nx_a[p] = 0; nx_b[p] = 0; nx_ins[p] = 0; nx_lat[p] = 0;
        end

        drain(3);
        nx_reset = 1'b0;
        drain(2);

        // plain ADD on port 0
        issue(0, 5'd6, 32'd5, 32'd7, 3);
        drain(8);
        chk("tp1_out", rlog.size() > 0 ? rlog[$] : 32'hdead, 32'd12);
        chk("tp1_flags", flog.size() > 0 ? flog[$] : 4'hf, 4'b0000);
        chk("tp1_id", ilog.size() > 0 ? ilog[$] : 7, 0);

        // both ports contending
        glog.delete();
        start = int'(!m_last);
        nx_valid = 2'b11;
        nx_ins[0] = 5'd6; nx_ins[1] = 5'd3;
        nx_lat[0] = 1; nx_lat[1] = 1;
        for (int i = 0; i < 60 && glog.size() < 4; i++) step();
        nx_valid = 2'b00;
        drain(6);
        chk("tp2_count", glog.size() >= 4, 1);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            chk("tp2_gnt", glog[i], (start + i) % 2);

        // illegal opcode
        issue(1, 5'd20, 32'h1234, 32'h5678, 0);
        drain(3);
        chk("tp3_flags", flog[$], 4'b1000);
        chk("tp3_out", rlog[$], 0);

        // watchdog then a normal op
        issue(0, 5'd3, 32'h11, 32'h22, 100);
        drain(12);
        chk("tp4_flags", flog[$], 4'b1000);
        issue(0, 5'd6, 32'd1, 32'd2, 2);
        drain(8);
        chk("tp4_next", rlog[$], 32'd3);

        // response back-pressure
        nx_rsp_ready = 1'b0;
        issue(1, 5'd7, 32'hcafe, 32'hbeef, 0);
        nx_valid = 2'b01;
        nx_ins[0] = 5'd6; nx_lat[0] = 0;
        drain(6);
        nx_rsp_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = hs_req;
        end
        nx_valid = 2'b00;
        chk("tp5_accept", ok, 1);
        drain(6);

        // reset mid-WAIT
        issue(0, 5'd6, 32'd9, 32'd9, 10);
        drain(3);
        nx_reset = 1'b1;
        step();
        nx_reset = 1'b0;
        step();
        glog.delete();
        nx_valid = 2'b11;
        nx_lat[0] = 0; nx_lat[1] = 0;
        for (int i = 0; i < 10 && glog.size() < 1; i++) step();
        nx_valid = 2'b00;
        chk("tp6_first", glog.size() > 0 ? glog[0] : 9, 0);
        drain(6);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            nx_reset = ($urandom_range(0, 199) == 0);
            nx_valid = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                nx_a[p] = $urandom;
                nx_b[p] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                nx_ins[p] = ($urandom_range(0, 3) == 0) ?
                            5'($urandom_range(16, 31)) :
                            5'($urandom_range(0, 15));
                nx_lat[p] = $urandom_range(0, 10);
            end
            nx_rsp_ready = $urandom_range(0, 3) != 0;
            step();
        end
        nx_reset = 1'b0;
        nx_valid = 2'b00;
        nx_rsp_ready = 1'b1;
        drain(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencer and two-port arbiter in front of the ALU. It accepts operation requests from the CU execute path (port 0) and the branch-resolution path (port 1), and arbitrates between them round-robin. It drives the ALU's dat_ready, operand and Instruction_to_ALU inputs, waits for ALU_ready, and captures the result and flags. It returns one response per accepted request through a valid/ready handshake, and enforces a watchdog timeout on the ALU.

Parameters:
TIMEOUT_CYCLES, 8, max cycles in WAIT before aborting with error (legal range 4..255)
MAX_OPCODE, 15, highest legal Instruction_to_ALU code; codes above are rejected without using the ALU

Ports:
soc_clk  in  1  single clock; all logic posedge
reset  in  1  synchronous, active-high reset
req_valid  in  2  per-port request valid; bit0 = CU, bit1 = branch
req_ready  out  2  per-port accept; one-hot or zero
req0_dat1, req0_dat2  in  32 each  port 0 operands
req0_instr  in  5  port 0 ALU instruction code
req1_dat1, req1_dat2  in  32 each  port 1 operands
req1_instr  in  5  port 1 ALU instruction code
alu_dat_ready  out  1  to ALU dat_ready
alu_dat1, alu_dat2  out  32 each  to ALU operands
alu_instr  out  5  to ALU Instruction_to_ALU
alu_ready  in  1  ALU_ready
alu_out  in  32  ALU_out
alu_overflow, alu_con_met, alu_zero  in  1 each  ALU flags
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer accept
rsp_id  out  1  port that issued the request
rsp_out  out  32  captured result
rsp_flags  out  4  {err, overflow, con_met, zero}

Behaviour:
- Reset values: req_ready=0, alu_dat_ready=0, alu_dat1/alu_dat2/alu_instr=0, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_flags=0, state=IDLE, last_grant=1 (so port 0 wins first), timeout counter=0.
- Reset asserted in any state returns to IDLE next edge. An in-flight op is discarded with no response, and alu_dat_ready drops immediately.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant one port. If both are valid, grant the port != last_grant. Otherwise grant the single valid port.
  - req_ready[g] is driven combinationally high in IDLE for the granted port only.
  - Transfer occurs when valid & ready. Capture dat1/dat2/instr into internal registers and set last_grant=g.
  - If instr > MAX_OPCODE, go to RESP with rsp_out=0 and flags=4'b1000. The ALU is not touched.
  - Otherwise go to WAIT.
- WAIT:
  - alu_dat_ready=1 and alu_* driven from captured registers, stable for the whole state.
  - Timeout counter increments each cycle.
  - On alu_ready=1: capture alu_out and flags (err=0), deassert alu_dat_ready next cycle, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES first: go to RESP with rsp_out=0 and flags=4'b1000.
  - The counter clears on leaving WAIT.
- RESP:
  - rsp_valid=1 with rsp_id/rsp_out/rsp_flags held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE; rsp_valid falls next cycle.
  - alu_dat_ready is 0 throughout RESP, guaranteeing at least one low cycle between ops.
- One op in flight at a time. req_ready is never high outside IDLE. Minimum issue-to-issue spacing is 3 cycles plus ALU latency.
- Latency, request acceptance to rsp_valid: 1 + (cycles until alu_ready) + 1.
- alu_ready arriving in the same cycle as a timeout is treated as success.
- req_valid dropping without a handshake: no state change, no grant-pointer update.

Optional Feature:
ALU_SEQ_PERF_EN:
- Defined: adds outputs perf_ops (32 bits) and perf_wait (32 bits).
  - perf_ops increments on each completed response handshake.
  - perf_wait increments on each cycle spent in WAIT.
  - Both clear on reset and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Port 0 only, instr=6 (ADD), dat1=5, dat2=7; ALU model returns 12 after 3 cycles -> rsp_valid with rsp_id=0, rsp_out=12, rsp_flags=0000; alu_dat_ready high exactly in WAIT.
2. Both ports valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 over 4 ops; req_ready never 2'b11.
3. Port 1, instr=20 -> rsp_flags=1000, rsp_out=0; alu_dat_ready never asserts.
4. ALU model never raises alu_ready, TIMEOUT_CYCLES=8 -> rsp_flags=1000 after 8 WAIT cycles; next request proceeds normally.
5. rsp_ready held low 5 cycles in RESP -> rsp_* stable for 5 cycles, req_ready=0; a new request is accepted only after the handshake.
6. Reset pulsed mid-WAIT -> next cycle alu_dat_ready=0, rsp_valid=0; the following port 0 request is granted first. With ALU_SEQ_PERF_EN, perf counters read 0.
